// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive path: parser states, protocol
// constants, header byte offsets and the byte-wide CRC-32 step.
package gmii_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ETH,
        S_IPH,
        S_UDPH,
        S_PID,
        S_RESOL,
        S_VIDEO,
        S_AUX,
        S_FCS,
        S_DROP
    } state_t;

    localparam logic [7:0]  PID_VIDEO    = 8'h00;
    localparam logic [7:0]  PID_AUDIO    = 8'h01;
    localparam logic [7:0]  PRE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE     = 8'hD5;

    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    // Header lengths and offsets of the checked fields, in bytes
    localparam logic [10:0] ETH_LEN       = 11'd14;
    localparam logic [10:0] ETH_TYPE_OFS  = 11'd12;
    localparam logic [10:0] IPH_LEN       = 11'd20;
    localparam logic [10:0] IPH_PROT_OFS  = 11'd9;
    localparam logic [10:0] UDPH_LEN      = 11'd8;
    localparam logic [10:0] UDP_DPORT_OFS = 11'd2;
    localparam logic [10:0] UDP_LEN_OFS   = 11'd4;

    // One byte of reflected CRC-32, LSB of the data first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r[0] ^ data[i]) ? ((r >> 1) ^ CRC_POLY_REF) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_rx_video_crc_chk.sv
// Byte-wide CRC-32 checker; residue is the bit-reversed register so that a
// frame followed by its own FCS leaves CRC_RESIDUE.
module crc_chk
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] residue
);

    logic [31:0] crc;

    // CRC register: preset on init, advance one byte on en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

    // Present the register MSB-first for comparison with the residue constant
    always_comb begin
        residue = {<<{crc}};
    end

endmodule

// File: rtl/gmii_rx_video.sv
// GMII receive parser: filters MAC/IP/UDP headers and streams video pixel
// pairs or aux bytes to their FIFOs, then reports per-frame FCS status.
module gmii_rx_video
    import gmii_pkg::*;
#(
    parameter logic [47:0] my_mac    = 48'h002345678902,
    parameter logic [15:0] ip_type   = 16'h0800,
    parameter logic [7:0]  ip_prot   = 8'h11,
    parameter logic [15:0] udp_dport = 16'd12345,
    parameter logic [15:0] udp_len   = 16'd1290,
    parameter logic [3:0]  max_pre   = 4'd7
) (
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        vid_we,
    output logic [27:0] vid_din,
    input  logic        vid_full,
    output logic        aux_we,
    output logic [7:0]  aux_din,
    input  logic        aux_full,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] drop_cnt
);

    // Index of the last payload byte, counting the PID byte as 0
    localparam logic [10:0] PAY_LAST = 11'(udp_len - 16'd9);

    logic        rx_dv_q, rx_er_q;
    logic [7:0]  rxd_q;
    state_t      state, state_n, hdr_next;
    logic [10:0] cnt, cnt_n, hdr_last;
    logic [11:0] line, line_n;
    logic [7:0]  y_hold, y_n, exp_byte, aux_byte;
    logic        err_flag, err_n, chk_en;
    logic [2:0]  fcs_cnt, fcs_n;
    logic        vid_we_n, aux_we_n, ok_n, bad_n, pix_wr, aux_wr;
    logic [27:0] vid_din_n, pix_word;
    logic [7:0]  aux_din_n;
    logic        crc_init, crc_en;
    logic [31:0] residue;
    logic [47:0] mac_eff;

    assign mac_eff = {my_mac[47:8], my_mac[7:0] - {7'd0, id}};

    crc_chk u_crc_chk (
        .clk     (rx_clk),
        .rst     (sys_rst),
        .init    (crc_init),
        .en      (crc_en),
        .data    (rxd_q),
        .residue (residue)
    );

    // Register the GMII inputs before parsing
    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_dv_q <= 1'b0;
            rx_er_q <= 1'b0;
            rxd_q   <= '0;
        end else begin
            rx_dv_q <= rx_dv;
            rx_er_q <= rx_er;
            rxd_q   <= rxd;
        end
    end

    // Parser state, counters and registered outputs
    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            line      <= '0;
            y_hold    <= '0;
            err_flag  <= 1'b0;
            fcs_cnt   <= '0;
            vid_we    <= 1'b0;
            vid_din   <= '0;
            aux_we    <= 1'b0;
            aux_din   <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            line      <= line_n;
            y_hold    <= y_n;
            err_flag  <= err_n;
            fcs_cnt   <= fcs_n;
            vid_we    <= vid_we_n;
            vid_din   <= vid_din_n;
            aux_we    <= aux_we_n;
            aux_din   <= aux_din_n;
            frame_ok  <= ok_n;
            frame_err <= bad_n;
            if (bad_n && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Next-state, header filtering and FIFO write generation
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        line_n    = line;
        y_n       = y_hold;
        err_n     = err_flag;
        fcs_n     = fcs_cnt;
        vid_we_n  = 1'b0;
        vid_din_n = vid_din;
        aux_we_n  = 1'b0;
        aux_din_n = aux_din;
        ok_n      = 1'b0;
        bad_n     = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        pix_wr    = 1'b0;
        pix_word  = '0;
        aux_wr    = 1'b0;
        aux_byte  = '0;
        exp_byte  = '0;
        chk_en    = 1'b0;
        hdr_last  = '0;
        hdr_next  = S_IDLE;

        // Which header byte is checked against what, and where each header ends
        case (state)
            S_ETH: begin
                hdr_last = ETH_LEN - 11'd1;
                hdr_next = S_IPH;
                chk_en   = 1'b1;
                case (cnt)
                    11'd0:                 exp_byte = mac_eff[47:40];
                    11'd1:                 exp_byte = mac_eff[39:32];
                    11'd2:                 exp_byte = mac_eff[31:24];
                    11'd3:                 exp_byte = mac_eff[23:16];
                    11'd4:                 exp_byte = mac_eff[15:8];
                    11'd5:                 exp_byte = mac_eff[7:0];
                    ETH_TYPE_OFS:          exp_byte = ip_type[15:8];
                    ETH_TYPE_OFS + 11'd1:  exp_byte = ip_type[7:0];
                    default:               chk_en   = 1'b0;
                endcase
            end
            S_IPH: begin
                hdr_last = IPH_LEN - 11'd1;
                hdr_next = S_UDPH;
                chk_en   = (cnt == IPH_PROT_OFS);
                exp_byte = ip_prot;
            end
            S_UDPH: begin
                hdr_last = UDPH_LEN - 11'd1;
                hdr_next = S_PID;
                chk_en   = 1'b1;
                case (cnt)
                    UDP_DPORT_OFS:         exp_byte = udp_dport[15:8];
                    UDP_DPORT_OFS + 11'd1: exp_byte = udp_dport[7:0];
                    UDP_LEN_OFS:           exp_byte = udp_len[15:8];
                    UDP_LEN_OFS + 11'd1:   exp_byte = udp_len[7:0];
                    default:               chk_en   = 1'b0;
                endcase
            end
            default: ;
        endcase

        case (state)
            S_IDLE: begin
                if (rx_dv_q) begin
                    state_n = (rxd_q == PRE_BYTE) ? S_PRE : S_DROP;
                    cnt_n   = 11'd1;
                    err_n   = 1'b0;
                end
            end
            S_PRE: begin
                if (!rx_dv_q) begin
                    state_n = S_IDLE;
                end else if (rxd_q == SFD_BYTE) begin
                    state_n  = S_ETH;
                    cnt_n    = '0;
                    crc_init = 1'b1;
                end else if (rxd_q == PRE_BYTE && cnt < {7'd0, max_pre}) begin
                    cnt_n = cnt + 11'd1;
                end else begin
                    state_n = S_DROP;
                end
            end
            S_ETH, S_IPH, S_UDPH: begin
                if (!rx_dv_q) begin
                    state_n = S_IDLE;
                end else begin
                    crc_en = 1'b1;
                    if (chk_en && rxd_q != exp_byte) begin
                        state_n = S_DROP;
                    end else if (cnt == hdr_last) begin
                        state_n = hdr_next;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
            end
            S_PID, S_RESOL, S_VIDEO, S_AUX: begin
                if (!rx_dv_q) begin
                    state_n = S_IDLE;
                    bad_n   = 1'b1;
                end else begin
                    crc_en = 1'b1;
                    cnt_n  = cnt + 11'd1;
                    if (rx_er_q) begin
                        err_n = 1'b1;
                    end
                    if (state == S_PID) begin
                        if (rxd_q == PID_VIDEO) begin
                            state_n = S_RESOL;
                        end else if (rxd_q == PID_AUDIO) begin
                            state_n = S_AUX;
                        end else begin
                            state_n = S_DROP;
                        end
                    end else if (state == S_RESOL) begin
                        if (cnt == 11'd1) begin
                            line_n[7:0] = rxd_q;
                        end else begin
                            line_n[11:8] = rxd_q[3:0];
                            state_n      = S_VIDEO;
                        end
                    end else if (state == S_VIDEO) begin
                        // Odd payload index carries Y; a Y that ends the payload is written alone
                        if (cnt[0]) begin
                            y_n = rxd_q;
                            if (cnt == PAY_LAST) begin
                                pix_wr   = 1'b1;
                                pix_word = {line, rxd_q, 8'h00};
                            end
                        end else begin
                            pix_wr   = 1'b1;
                            pix_word = {line, y_hold, rxd_q};
                        end
                    end else begin
                        aux_wr   = 1'b1;
                        aux_byte = rxd_q;
                    end
                    if ((state == S_VIDEO || state == S_AUX) && cnt == PAY_LAST) begin
                        state_n = S_FCS;
                        fcs_n   = '0;
                    end
                end
            end
            S_FCS: begin
                if (!rx_dv_q) begin
                    state_n = S_IDLE;
                    if (fcs_cnt == 3'd4 && residue == CRC_RESIDUE && !err_flag) begin
                        ok_n = 1'b1;
                    end else begin
                        bad_n = 1'b1;
                    end
                end else begin
                    crc_en = 1'b1;
                    if (rx_er_q) begin
                        err_n = 1'b1;
                    end
                    if (fcs_cnt != 3'd7) begin
                        fcs_n = fcs_cnt + 3'd1;
                    end
                end
            end
            S_DROP: begin
                if (!rx_dv_q) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // A write into a full FIFO is discarded and spoils the frame
        if (pix_wr) begin
            if (vid_full) begin
                err_n = 1'b1;
            end else begin
                vid_we_n  = 1'b1;
                vid_din_n = pix_word;
            end
        end
        if (aux_wr) begin
            if (aux_full) begin
                err_n = 1'b1;
            end else begin
                aux_we_n  = 1'b1;
                aux_din_n = aux_byte;
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_video.sv
// Randomized bench for gmii_rx_video with a frame-level reference model.
module tb_gmii_rx_video;

    localparam int UDP_LEN = 1290;
    localparam int NPAY    = UDP_LEN - 8;
    localparam int PID_IDX = 50;

    logic        rx_clk = 1'b0;
    logic        sys_rst, id, rx_dv, rx_er, vid_full, aux_full;
    logic [7:0]  rxd;
    logic        vid_we, aux_we, frame_ok, frame_err;
    logic [27:0] vid_din;
    logic [7:0]  aux_din;
    logic [15:0] drop_cnt;

    gmii_rx_video #(.udp_len(16'd1290), .max_pre(4'd7)) dut (
        .rx_clk    (rx_clk),
        .sys_rst   (sys_rst),
        .id        (id),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .rxd       (rxd),
        .vid_we    (vid_we),
        .vid_din   (vid_din),
        .vid_full  (vid_full),
        .aux_we    (aux_we),
        .aux_din   (aux_din),
        .aux_full  (aux_full),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt)
    );

    always #4 rx_clk = ~rx_clk;

    int unsigned cyc = 0;
    always @(posedge rx_clk) cyc++;

    typedef struct { int unsigned cyc; logic [27:0] d; } ev_t;
    typedef struct { int idx; logic [27:0] d; } trig_t;

    ev_t         vid_q[$], aux_q[$], st_q[$];
    trig_t       vt[$], at[$];
    logic [7:0]  frm[$];
    bit          accepted;
    int unsigned n_assert = 0, n_fail = 0;
    int unsigned vid_seen, aux_seen, ok_seen, err_seen;
    int unsigned model_drops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Assemble one wire frame and derive the writes it must produce
    task automatic build(input bit video, input logic [11:0] line, input logic [7:0] mac_last,
                         input logic [7:0] pid, input bit flip);
        logic [31:0] c;
        logic [11:0] lv;
        logic [7:0]  m;
        int          fi, npix;
        frm.delete(); vt.delete(); at.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        frm.push_back(8'h00); frm.push_back(8'h23); frm.push_back(8'h45);
        frm.push_back(8'h67); frm.push_back(8'h89); frm.push_back(mac_last);
        repeat (6) frm.push_back(8'($urandom));
        frm.push_back(8'h08); frm.push_back(8'h00);
        for (int i = 0; i < 20; i++)
            frm.push_back(i == 0 ? 8'h45 : (i == 9 ? 8'h11 : 8'($urandom)));
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        frm.push_back(8'h30); frm.push_back(8'h39);
        frm.push_back(8'h05); frm.push_back(8'h0A);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        frm.push_back(pid);
        if (video) begin
            frm.push_back(line[7:0]);
            frm.push_back({4'($urandom), line[11:8]});
            repeat (NPAY - 3) frm.push_back(8'($urandom));
        end else begin
            repeat (NPAY - 1) frm.push_back(8'($urandom));
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < frm.size(); i++) c = crc_upd(c, frm[i]);
        if (flip) begin
            fi = $urandom_range(PID_IDX + NPAY - 1, PID_IDX + 3);
            m = 8'h01 << $urandom_range(7, 0);
            frm[fi] = frm[fi] ^ m;
        end
        c = ~c;
        frm.push_back(c[7:0]); frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);

        accepted = (mac_last == 8'h02 - 8'(id)) && (pid == 8'h00 || pid == 8'h01);
        if (accepted && pid == 8'h00) begin
            lv   = {frm[PID_IDX + 2][3:0], frm[PID_IDX + 1]};
            npix = NPAY - 3;
            for (int k = 0; k < npix; k += 2) begin
                if (k + 1 < npix)
                    vt.push_back('{PID_IDX + 4 + k, {lv, frm[PID_IDX + 3 + k], frm[PID_IDX + 4 + k]}});
                else
                    vt.push_back('{PID_IDX + 3 + k, {lv, frm[PID_IDX + 3 + k], 8'h00}});
            end
        end
        if (accepted && pid == 8'h01) begin
            for (int p = 1; p < NPAY; p++) at.push_back('{PID_IDX + p, {20'd0, frm[PID_IDX + p]}});
        end
    endtask

    task automatic flush_pending();
        while (vid_q.size() > 0 && vid_q[$].cyc >= cyc) void'(vid_q.pop_back());
        while (aux_q.size() > 0 && aux_q[$].cyc >= cyc) void'(aux_q.pop_back());
        while (st_q.size() > 0 && st_q[$].cyc >= cyc) void'(st_q.pop_back());
    endtask

    // Drive frm[0..cut-1]; st: 0 none, 1 ok, 2 err; rst_at<0 means no reset pulse
    task automatic drive(input int cut, input int st, input int er_idx, input int rst_at, input bit fill);
        bit killed;
        int vi, ai;
        killed = 0; vi = 0; ai = 0;
        vid_seen = 0; aux_seen = 0; ok_seen = 0; err_seen = 0;
        vid_full = fill; aux_full = fill;
        for (int j = 0; j < cut; j++) begin
            @(posedge rx_clk); #1;
            if (j == rst_at) begin
                sys_rst = 1'b1;
                killed = 1;
                flush_pending();
                model_drops = 0;
                #1;
                chk("rst_vid_we", 32'(vid_we), 32'd0);
                chk("rst_aux_we", 32'(aux_we), 32'd0);
                chk("rst_frame_ok", 32'(frame_ok), 32'd0);
                chk("rst_frame_err", 32'(frame_err), 32'd0);
                chk("rst_vid_din", 32'(vid_din), 32'd0);
                chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
            end
            if (rst_at >= 0 && j == rst_at + 3) sys_rst = 1'b0;
            rx_dv = 1'b1;
            rxd   = frm[j];
            rx_er = (j == er_idx);
            if (!killed) begin
                while (vi < vt.size() && vt[vi].idx == j) begin
                    vid_q.push_back('{cyc + 2, vt[vi].d}); vi++;
                end
                while (ai < at.size() && at[ai].idx == j) begin
                    aux_q.push_back('{cyc + 2, at[ai].d}); ai++;
                end
            end
        end
        @(posedge rx_clk); #1;
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        if (!killed && st != 0) st_q.push_back('{cyc + 2, 28'(st)});
        repeat (12 + $urandom_range(4, 0)) @(posedge rx_clk);
        #1;
        vid_full = 1'b0; aux_full = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every output strobe against the model
    always @(negedge rx_clk) begin
        bit         e;
        logic [1:0] es;
        e = vid_q.size() > 0 && vid_q[0].cyc == cyc;
        if (vid_we || e) begin
            chk("vid_we", 32'(vid_we), 32'(e));
            if (vid_we && e) chk("vid_din", 32'(vid_din), 32'(vid_q[0].d));
            if (e) void'(vid_q.pop_front());
        end
        if (vid_we) vid_seen++;
        e = aux_q.size() > 0 && aux_q[0].cyc == cyc;
        if (aux_we || e) begin
            chk("aux_we", 32'(aux_we), 32'(e));
            if (aux_we && e) chk("aux_din", 32'(aux_din), 32'(aux_q[0].d));
            if (e) void'(aux_q.pop_front());
        end
        if (aux_we) aux_seen++;
        es = 2'b00;
        if (st_q.size() > 0 && st_q[0].cyc == cyc) es = (st_q[0].d == 28'd1) ? 2'b01 : 2'b10;
        if (frame_ok || frame_err || es != 2'b00) begin
            if (es == 2'b10 && model_drops != 32'd65535) model_drops++;
            chk("status", 32'({frame_err, frame_ok}), 32'(es));
            chk("drop_cnt", 32'(drop_cnt), model_drops);
            if (es != 2'b00) void'(st_q.pop_front());
        end
        if (frame_ok)  ok_seen++;
        if (frame_err) err_seen++;
    end

    initial begin
        int  len, cut, er, st;
        bit  video, flip, fill;
        logic [7:0] pid;

        sys_rst = 1'b1; id = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        vid_full = 1'b0; aux_full = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        chk("reset_vid_we", 32'(vid_we), 32'd0);
        chk("reset_aux_we", 32'(aux_we), 32'd0);
        chk("reset_frame_ok", 32'(frame_ok), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        sys_rst = 1'b0;
        repeat (3) @(posedge rx_clk);

        // Good video frame, line 2CF
        build(1, 12'h2CF, 8'h02, 8'h00, 0);
        chk("frame_len", frm.size(), 32'd1336);
        drive(frm.size(), 1, -1, -1, 0);
        chk("good_vid_count", vid_seen, 32'd640);
        chk("good_ok", ok_seen, 32'd1);
        chk("good_err", err_seen, 32'd0);
        chk("good_last_line", 32'(vid_din[27:16]), 32'h2CF);
        chk("good_last_c", 32'(vid_din[7:0]), 32'h00);

        // Payload bit flipped
        build(1, 12'h2CF, 8'h02, 8'h00, 1);
        drive(frm.size(), 2, -1, -1, 0);
        chk("flip_vid_count", vid_seen, 32'd640);
        chk("flip_err", err_seen, 32'd1);
        chk("flip_drop_cnt", 32'(drop_cnt), 32'd1);

        // Audio frame
        build(0, 12'h000, 8'h02, 8'h01, 0);
        drive(frm.size(), 1, -1, -1, 0);
        chk("aux_count", aux_seen, 32'd1281);
        chk("aux_ok", ok_seen, 32'd1);

        // Board select: id=1 accepts MAC ending 01 only
        id = 1'b1;
        build(1, 12'($urandom), 8'h02, 8'h00, 0);
        drive(frm.size(), 0, -1, -1, 0);
        chk("id_drop_writes", vid_seen, 32'd0);
        chk("id_drop_status", ok_seen + err_seen, 32'd0);
        build(1, 12'($urandom), 8'h01, 8'h00, 0);
        drive(frm.size(), 1, -1, -1, 0);
        chk("id_accept_writes", vid_seen, 32'd640);
        chk("id_accept_ok", ok_seen, 32'd1);
        id = 1'b0;

        // rx_dv drops after 100 pixel bytes
        build(1, 12'($urandom), 8'h02, 8'h00, 0);
        drive(PID_IDX + 3 + 100, 2, -1, -1, 0);
        chk("trunc_vid_count", vid_seen, 32'd50);
        chk("trunc_err", err_seen, 32'd1);
        chk("trunc_drop_cnt", 32'(drop_cnt), 32'd2);
        build(1, 12'($urandom), 8'h02, 8'h00, 0);
        drive(frm.size(), 1, -1, -1, 0);
        chk("after_trunc_ok", ok_seen, 32'd1);

        // Reset in the middle of the video payload
        build(1, 12'($urandom), 8'h02, 8'h00, 0);
        drive(frm.size(), 0, -1, 400, 0);
        chk("rst_frame_status", ok_seen + err_seen, 32'd0);
        chk("rst_drop_after", 32'(drop_cnt), 32'd0);
        build(1, 12'($urandom), 8'h02, 8'h00, 0);
        drive(frm.size(), 1, -1, -1, 0);
        chk("after_rst_ok", ok_seen, 32'd1);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            video = 1'($urandom_range(1, 0));
            pid   = video ? 8'h00 : 8'h01;
            if ($urandom_range(5, 0) == 0) pid = 8'($urandom_range(255, 2));
            flip  = ($urandom_range(3, 0) == 0);
            fill  = ($urandom_range(5, 0) == 0);
            build(video, 12'($urandom), 8'h02, pid, flip);
            len = frm.size();
            cut = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 60)) : len;
            er  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(len - 1, PID_IDX + 1)) : -1;
            if (fill && accepted) begin
                vt.delete(); at.delete();
            end
            if (!accepted) st = 0;
            else if (flip || fill || cut < len || (er >= 0 && er < cut)) st = 2;
            else st = 1;
            drive(cut, st, er, -1, fill);
            chk("rand_status_count", ok_seen + err_seen, (st != 0) ? 32'd1 : 32'd0);
        end

        repeat (5) @(posedge rx_clk);
        chk("pending_vid", vid_q.size(), 32'd0);
        chk("pending_aux", aux_q.size(), 32'd0);
        chk("pending_status", st_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_video.md
# gmii_rx_video

Receive-side counterpart of the GMII video/audio transmitter. It sits between the Ethernet PHY GMII receive pins and the receive-side video and aux FIFOs. It parses each frame byte by byte, filters on MAC/IP/UDP fields, and streams video pixel pairs and aux bytes to the FIFOs. It reports per-frame FCS status once the frame ends.

## Interface
Parameters:
- my_mac, 48'h002345678902: accepted destination MAC; the last byte is reduced by `id`.
- ip_type, 16'h0800: required EtherType.
- ip_prot, 8'h11: required IP protocol (UDP).
- udp_dport, 16'd12345: required UDP destination port.
- udp_len, 16'd1290: expected UDP length; payload bytes = udp_len − 8.
- max_pre, 4'd7: maximum 0x55 preamble bytes before 0xD5.

Ports:
- rx_clk  in  1  GMII receive clock (125 MHz); the only clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- id  in  1  board select; subtracted from my_mac[7:0].
- rx_dv  in  1  GMII data valid.
- rx_er  in  1  GMII receive error.
- rxd  in  8  GMII receive data.
- vid_we  out  1  video FIFO write strobe.
- vid_din  out  28  {line[11:0], Y[7:0], C[7:0]}.
- vid_full  in  1  video FIFO full.
- aux_we  out  1  aux FIFO write strobe.
- aux_din  out  8  aux payload byte.
- aux_full  in  1  aux FIFO full.
- frame_ok  out  1  one-cycle pulse: accepted frame ended with good FCS.
- frame_err  out  1  one-cycle pulse: accepted frame ended badly (FCS, rx_er, runt, overflow).
- drop_cnt  out  16  count of frame_err pulses; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE → PRE → ETH → IPH → UDPH → PID → RESOL → VIDEO | AUX → FCS → IDLE, plus DROP.
- IDLE
  - rx_dv=1 and rxd=0x55 → PRE.
  - rx_dv=1 and any other byte → DROP.
- PRE
  - 0xD5 → ETH; the CRC is initialised on this cycle.
  - 0x55 beyond max_pre, or any other byte → DROP.
- Header checks:
  - ETH bytes 0–5 must equal dst MAC; bytes 12–13 must equal ip_type.
  - IPH byte 9 must equal ip_prot.
  - UDPH bytes 2–3 must equal udp_dport; bytes 4–5 must equal udp_len.
  - Any mismatch → DROP, silently, with no frame_err.
- PID: byte 0x00 → RESOL; 0x01 → AUX; other → DROP.
- RESOL: byte0 = line[7:0], byte1 = {flags[3:0], line[11:8]}; the 12-bit line is latched.
- VIDEO
  - Bytes are paired: even byte = Y, odd byte = C.
  - vid_we pulses on each completed pair.
  - If the pixel-byte count (udp_len − 11) is odd, the last Y is written with C = 8'h00.
- AUX: every byte after PID is written to aux_din; this covers udp_len − 9 bytes.
- Payload byte counter is 11 bits and compares against udp_len − 8 − 1.
- FCS
  - The 4 FCS bytes are fed through the CRC.
  - At rx_dv fall, the residue is compared with 32'hC704DD7B.
  - Match → frame_ok; otherwise → frame_err.
- DROP: wait for rx_dv=0, then go to IDLE.
- Errors:
  - rx_er=1 in any accepted state (PID onward) → frame_err at rx_dv fall.
  - rx_dv falling before FCS complete → frame_err, then IDLE.
  - A write while the target FIFO is full discards that word, marks overflow, and gives frame_err at end of frame.
- Payload already written for a bad frame is not retracted; the downstream consumer uses frame_ok/frame_err.

## Timing
- rxd is registered on input; vid_we/aux_we assert 2 rx_clk cycles after the completing byte is on rxd.
- frame_ok/frame_err assert 2 cycles after the first rx_dv=0 cycle.
- Back-to-back frames with the minimum IFG (12 idle cycles) are accepted.
- Reset values: every output is 0, state=IDLE, CRC=32'hFFFFFFFF.
- Reset asserted mid-frame: outputs clear immediately. After release, the block waits in IDLE for a fresh preamble; the partial frame gets no status pulse.
- Simultaneous frame_err and drop_cnt increment happen in the same cycle.

## Structure
- Shared package (gmii_pkg): state encodings, PID constants (video=8'h00, audio=8'h01), preamble/SFD bytes, CRC residue constant, header byte offsets.
- Sub-module: crc_chk. It is byte-wide CRC-32 (poly 04C11DB7, reflected) with init, en and residue output, and sits parallel to the existing crc_gen.

## Test plan
- Good video frame, udp_len=1290, line=12'h2CF → 640 vid_we with vid_din[27:16]=12'h2CF; the last word has C=00; one frame_ok.
- Same frame with one payload bit flipped → 640 writes, then frame_err; drop_cnt=1.
- Audio frame (PID=01), udp_len=1290 → 1281 aux_we in rxd order; frame_ok.
- Dst MAC last byte 0x02 with id=1 → dropped silently: no writes, no status pulse. The same frame with 0x01 is accepted.
- rx_dv drops after 100 pixel bytes → 50 vid_we, then frame_err 2 cycles later; the next good frame is accepted.
- sys_rst pulsed mid-VIDEO → outputs 0 immediately; the following good frame gives frame_ok.
